iob_ila_dump: RTL and testbench

Hardware readout engine for the ILA: an IOb-native initiator that drives the ILA's software register port to read back a complete capture and emits it as a stream. On `start_i` it reads `N_SAMPLES`. For each sample index it writes `INDEX`, then for each data word writes `SIGNAL_SELECT` and reads `SAMPLE_DATA`. Each word goes out on a valid/ready stream, so a UART or DMA sink can dump captures without CPU involvement.

---
 rtl/iob_ila_dump_if.sv | 31 +++
 rtl/iob_ila_dump.sv | 176 +++++++++++++++++
 tb/tb_iob_ila_dump.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_ila_dump_if.sv
// IOb initiator request/response channel plus the outbound sample stream of iob_ila_dump.
interface iob_ila_dump_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic                  iob_valid_o;
  logic [ADDR_W-1:0]     iob_addr_o;
  logic [DATA_W-1:0]     iob_wdata_o;
  logic [DATA_W/8-1:0]   iob_wstrb_o;
  logic                  iob_ready_i;
  logic                  iob_rvalid_i;
  logic [DATA_W-1:0]     iob_rdata_i;
  logic [DATA_W-1:0]     tdata_o;
  logic                  tvalid_o;
  logic                  tready_i;
  logic                  tlast_o;

  modport master (
    output iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o,
    input  iob_ready_i, iob_rvalid_i, iob_rdata_i,
    output tdata_o, tvalid_o, tlast_o,
    input  tready_i
  );

  modport slave (
    input  iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o,
    output iob_ready_i, iob_rvalid_i, iob_rdata_i,
    input  tdata_o, tvalid_o, tlast_o,
    output tready_i
  );
endinterface

// File: rtl/iob_ila_dump.sv
// ILA capture readout engine: walks N_SAMPLES/INDEX/SIGNAL_SELECT/SAMPLE_DATA over IOb and streams words.
// Optional header beat {16'hA5A5, n} when IOB_ILA_DUMP_HEADER_EN is defined.
module iob_ila_dump #(
  parameter int              ADDR_W             = 8,
  parameter int              DATA_W             = 32,
  parameter int              WORDS_PER_SAMPLE   = 2,
  parameter logic [ADDR_W-1:0] N_SAMPLES_ADDR     = ADDR_W'(8'h18),
  parameter logic [ADDR_W-1:0] INDEX_ADDR         = ADDR_W'(8'h0C),
  parameter logic [ADDR_W-1:0] SIGNAL_SELECT_ADDR = ADDR_W'(8'h10),
  parameter logic [ADDR_W-1:0] SAMPLE_DATA_ADDR   = ADDR_W'(8'h14)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cke_i,
  input  logic            start_i,
  output logic            busy_o,
  output logic            done_o,
  iob_ila_dump_if.master  bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int W_W    = (WORDS_PER_SAMPLE > 1) ? $clog2(WORDS_PER_SAMPLE) : 1;
  localparam logic [W_W-1:0] W_LAST = W_W'(WORDS_PER_SAMPLE - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_N, S_WAIT_N, S_HDR, S_WR_IDX,
    S_WR_SEL, S_RD_DAT, S_WAIT_DAT, S_PUSH, S_FIN
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              last;
  } strm_t;

  state_t          state_q, state_d;
  logic [15:0]     n_q, n_d;
  logic [15:0]     idx_q, idx_d;
  logic [W_W-1:0]  w_q, w_d;
  req_t            req_q, req_d;
  strm_t           strm_q, strm_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [DATA_W-1:0] data_d;

  logic iob_acc, t_hs;
  assign iob_acc = req_q.valid & bus.iob_ready_i;
  assign t_hs    = strm_q.valid & bus.tready_i;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    w_d     = w_q;
    data_d  = strm_q.data;

    case (state_q)
      S_IDLE:     if (start_i) state_d = S_RD_N;
      S_RD_N:     if (iob_acc) state_d = S_WAIT_N;
      S_WAIT_N: begin
        if (bus.iob_rvalid_i) begin
          n_d   = bus.iob_rdata_i[15:0];
          idx_d = '0;
          w_d   = '0;
`ifdef IOB_ILA_DUMP_HEADER_EN
          state_d = S_HDR;
          data_d  = DATA_W'({16'hA5A5, bus.iob_rdata_i[15:0]});
`else
          state_d = (bus.iob_rdata_i[15:0] == 16'd0) ? S_FIN : S_WR_IDX;
`endif
        end
      end
`ifdef IOB_ILA_DUMP_HEADER_EN
      S_HDR:      if (t_hs) state_d = (n_q == 16'd0) ? S_FIN : S_WR_IDX;
`endif
      S_WR_IDX:   if (iob_acc) state_d = S_WR_SEL;
      S_WR_SEL:   if (iob_acc) state_d = S_RD_DAT;
      S_RD_DAT:   if (iob_acc) state_d = S_WAIT_DAT;
      S_WAIT_DAT: begin
        if (bus.iob_rvalid_i) begin
          data_d  = bus.iob_rdata_i;
          state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        if (t_hs) begin
          if (w_q != W_LAST) begin
            w_d     = w_q + W_W'(1);
            state_d = S_WR_SEL;
          end else if (idx_q != n_q - 16'd1) begin
            w_d     = '0;
            idx_d   = idx_q + 16'd1;
            state_d = S_WR_IDX;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so every one of them leaves a flop.
    req_d = '0;
    case (state_d)
      S_RD_N: begin
        req_d.valid = 1'b1;
        req_d.addr  = N_SAMPLES_ADDR;
      end
      S_WR_IDX: begin
        req_d.valid = 1'b1;
        req_d.addr  = INDEX_ADDR;
        req_d.wdata = DATA_W'(idx_d);
        req_d.wstrb = '1;
      end
      S_WR_SEL: begin
        req_d.valid = 1'b1;
        req_d.addr  = SIGNAL_SELECT_ADDR;
        req_d.wdata = DATA_W'(w_d);
        req_d.wstrb = '1;
      end
      S_RD_DAT: begin
        req_d.valid = 1'b1;
        req_d.addr  = SAMPLE_DATA_ADDR;
      end
      default: req_d = '0;
    endcase

    strm_d.data  = data_d;
    strm_d.valid = (state_d == S_PUSH) || (state_d == S_HDR);
    strm_d.last  = ((state_d == S_PUSH) && (idx_d == n_d - 16'd1) && (w_d == W_LAST)) ||
                   ((state_d == S_HDR) && (n_d == 16'd0));
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      w_q     <= '0;
      req_q   <= '0;
      strm_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (cke_i) begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      w_q     <= w_d;
      req_q   <= req_d;
      strm_q  <= strm_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign bus.iob_valid_o = req_q.valid;
  assign bus.iob_addr_o  = req_q.addr;
  assign bus.iob_wdata_o = req_q.wdata;
  assign bus.iob_wstrb_o = req_q.wstrb;
  assign bus.tdata_o     = strm_q.data;
  assign bus.tvalid_o    = strm_q.valid;
  assign bus.tlast_o     = strm_q.last;

endmodule

// File: tb/tb_iob_ila_dump.sv
// Bench for iob_ila_dump: behavioural ILA register slave, stream sink and list-based expected dump.
module tb_iob_ila_dump;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int WPS    = 2;
  localparam logic [7:0] A_N   = 8'h18;
  localparam logic [7:0] A_IDX = 8'h0C;
  localparam logic [7:0] A_SEL = 8'h10;
  localparam logic [7:0] A_DAT = 8'h14;
`ifdef IOB_ILA_DUMP_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int BEAT_CYC = 1 + 4 * WPS;

  logic clk = 1'b0, rst = 1'b1, cke = 1'b1, start = 1'b0;
  logic busy, done;

  iob_ila_dump_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  iob_ila_dump #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS_PER_SAMPLE(WPS)) dut (
    .clk_i(clk), .rst_i(rst), .cke_i(cke), .start_i(start),
    .busy_o(busy), .done_o(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;

  logic [15:0] n_reg = '0;
  logic [31:0] index_reg = '0, sel_reg = '0, salt = '0;
  bit stall_en = 0, hold_rd = 0, spam = 0;
  int lat_max = 0;
  bit rd_pend = 0;
  logic [31:0] rd_data = '0;
  logic [7:0] rd_addr = '0;
  int rd_wait = 0, i_stall = 0, t_stall = 0, done_cnt = 0;

  logic p_valid = 0, p_ready = 0, p_tvalid = 0, p_tready = 0, p_tlast = 0;
  logic [7:0]  p_addr = '0;
  logic [31:0] p_wdata = '0, p_tdata = '0;
  logic [3:0]  p_wstrb = '0;
  logic [31:0] beat_q[$];
  bit          last_q[$];

  // One clock of slave + sink behaviour, evaluated on the falling edge.
  task automatic tick();
    bit acc, hs, live;
    logic [15:0] junk;
    @(negedge clk);
    live = cke && !rst;
    acc  = p_valid && p_ready && live;
    hs   = p_tvalid && p_tready && live;
    if (acc) begin
      if (p_addr == A_IDX || p_addr == A_SEL) begin
        nvec++;
        if (p_wstrb !== 4'hF) begin nerr++; $display("FAIL wstrb_wr: got %h expected f", p_wstrb); end
        if (p_addr == A_IDX) index_reg = p_wdata; else sel_reg = p_wdata;
      end else begin
        nvec++;
        if (p_wstrb !== 4'h0) begin nerr++; $display("FAIL wstrb_rd: got %h expected 0", p_wstrb); end
        junk    = 16'($urandom);
        rd_pend = 1;
        rd_addr = p_addr;
        rd_wait = (lat_max > 0) ? $urandom_range(0, lat_max) : 0;
        if (p_addr == A_N)        rd_data = {junk, n_reg};
        else if (p_addr == A_DAT) rd_data = {index_reg[15:0], sel_reg[15:0]} ^ salt;
        else                      rd_data = '0;
      end
    end
    if (hs) begin beat_q.push_back(p_tdata); last_q.push_back(p_tlast); end
    if (p_valid && !acc && !rst) begin
      nvec++;
      if (bus.iob_valid_o !== 1'b1 || bus.iob_addr_o !== p_addr || bus.iob_wdata_o !== p_wdata ||
          bus.iob_wstrb_o !== p_wstrb) begin
        nerr++;
        $display("FAIL iob_hold: got v%b a%h d%h s%h expected v1 a%h d%h s%h", bus.iob_valid_o,
                 bus.iob_addr_o, bus.iob_wdata_o, bus.iob_wstrb_o, p_addr, p_wdata, p_wstrb);
      end
    end
    if (p_tvalid && !hs && !rst) begin
      nvec++;
      if (bus.tvalid_o !== 1'b1 || bus.tdata_o !== p_tdata || bus.tlast_o !== p_tlast) begin
        nerr++;
        $display("FAIL stream_hold: got v%b d%h l%b expected v1 d%h l%b", bus.tvalid_o, bus.tdata_o,
                 bus.tlast_o, p_tdata, p_tlast);
      end
    end
    if (rd_pend) begin
      nvec++;
      if (bus.iob_valid_o !== 1'b0) begin nerr++; $display("FAIL outstanding: got valid %b expected 0", bus.iob_valid_o); end
    end
    if (done === 1'b1) done_cnt++;
    // read response; garbage rdata and spurious rvalid outside waits must be ignored
    bus.iob_rvalid_i = 1'b0;
    bus.iob_rdata_i  = $urandom;
    if (rd_pend && !hold_rd) begin
      if (rd_wait == 0) begin
        bus.iob_rvalid_i = 1'b1;
        bus.iob_rdata_i  = rd_data;
        rd_pend = 0;
      end else rd_wait--;
    end else if (!rd_pend && stall_en && $urandom_range(0, 7) == 0) begin
      bus.iob_rvalid_i = 1'b1;
    end
    if (!stall_en) bus.iob_ready_i = 1'b1;
    else if (bus.iob_valid_o === 1'b1) begin
      if (i_stall > 0) begin bus.iob_ready_i = 1'b0; i_stall--; end
      else begin bus.iob_ready_i = 1'b1; i_stall = $urandom_range(0, 5); end
    end else bus.iob_ready_i = 1'($urandom_range(0, 1));
    if (!stall_en) bus.tready_i = 1'b1;
    else if (bus.tvalid_o === 1'b1) begin
      if (t_stall > 0) begin bus.tready_i = 1'b0; t_stall--; end
      else begin bus.tready_i = 1'b1; t_stall = $urandom_range(0, 5); end
    end else bus.tready_i = 1'($urandom_range(0, 1));
    if (spam) start = (busy === 1'b1 && done !== 1'b1) ? 1'($urandom_range(0, 1)) : 1'b0;
    p_valid  = bus.iob_valid_o;
    p_addr   = bus.iob_addr_o;
    p_wdata  = bus.iob_wdata_o;
    p_wstrb  = bus.iob_wstrb_o;
    p_ready  = bus.iob_ready_i;
    p_tvalid = bus.tvalid_o;
    p_tdata  = bus.tdata_o;
    p_tlast  = bus.tlast_o;
    p_tready = bus.tready_i;
  endtask

  // Full dump of n samples, compared against the list the ILA readout should produce.
  task automatic run_dump(input int n, input bit stl, input int fb, input int exp_k, input string tag);
    logic [31:0] exp_d[$];
    bit          exp_l[$];
    int k, budget, m;
    bit frozen;
    if (HDR != 0) begin exp_d.push_back({16'hA5A5, 16'(n)}); exp_l.push_back(n == 0); end
    for (int i = 0; i < n; i++)
      for (int w = 0; w < WPS; w++) begin
        exp_d.push_back({16'(i), 16'(w)} ^ salt);
        exp_l.push_back(i == n - 1 && w == WPS - 1);
      end
    beat_q.delete(); last_q.delete();
    done_cnt = 0; n_reg = 16'(n); stall_en = stl; lat_max = stl ? 3 : 0;
    i_stall = 0; t_stall = 0; frozen = 0;
    budget = 200 + n * BEAT_CYC * 8;
    start = 1'b1;
    tick();
    start = 1'b0;
    nvec++;
    if (bus.iob_valid_o !== 1'b1 || busy !== 1'b1) begin
      nerr++; $display("FAIL %s start_latency: got valid %b busy %b expected 1 1", tag, bus.iob_valid_o, busy);
    end
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      if (fb >= 0 && !frozen && bus.tvalid_o === 1'b1 && beat_q.size() == fb) begin
        frozen = 1; cke = 1'b0;
        repeat (10) begin tick(); k++; end
        cke = 1'b1;
      end
      tick(); k++;
    end
    nvec++;
    if (done_cnt == 0) begin nerr++; $display("FAIL %s done_timeout: got no done in %0d cycles expected done", tag, k); end
    if (exp_k >= 0) begin
      nvec++;
      if (k != exp_k) begin nerr++; $display("FAIL %s done_latency: got %0d expected %0d", tag, k, exp_k); end
    end
    repeat (4) tick();
    nvec++;
    if (done_cnt != 1) begin nerr++; $display("FAIL %s done_count: got %0d expected 1", tag, done_cnt); end
    nvec++;
    if (beat_q.size() != exp_d.size()) begin
      nerr++; $display("FAIL %s beat_count: got %0d expected %0d", tag, beat_q.size(), exp_d.size());
    end
    m = (beat_q.size() < exp_d.size()) ? beat_q.size() : exp_d.size();
    for (int i = 0; i < m; i++) begin
      nvec++;
      if (beat_q[i] !== exp_d[i] || last_q[i] !== exp_l[i]) begin
        nerr++;
        $display("FAIL %s beat%0d: got %h last %b expected %h last %b", tag, i, beat_q[i], last_q[i], exp_d[i], exp_l[i]);
      end
    end
    stall_en = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.iob_ready_i = 1'b0; bus.iob_rvalid_i = 1'b0; bus.iob_rdata_i = '0; bus.tready_i = 1'b0;
    repeat (2) tick();
    nvec++;
    if ({busy, done, bus.iob_valid_o, bus.tvalid_o, bus.tlast_o} !== 5'b0) begin
      nerr++; $display("FAIL rst_ctrl: got %b expected 00000", {busy, done, bus.iob_valid_o, bus.tvalid_o, bus.tlast_o});
    end
    nvec++;
    if ({bus.iob_addr_o, bus.iob_wstrb_o} !== 12'h0) begin
      nerr++; $display("FAIL rst_addr_strb: got %h expected 000", {bus.iob_addr_o, bus.iob_wstrb_o});
    end
    nvec++;
    if ({bus.iob_wdata_o, bus.tdata_o} !== 64'h0) begin
      nerr++; $display("FAIL rst_data: got %h expected 0", {bus.iob_wdata_o, bus.tdata_o});
    end
    rst = 1'b0;
    repeat (3) tick();
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL idle_no_start: got busy %b expected 0", busy); end
  endtask

  task automatic test_basic();
    salt = '0;
    run_dump(3, 0, -1, 2 + HDR + 3 * BEAT_CYC, "basic3");
    salt = $urandom;
    run_dump(1, 0, -1, 2 + HDR + BEAT_CYC, "single");
    run_dump(256, 0, -1, 2 + HDR + 256 * BEAT_CYC, "n256");
  endtask

  task automatic test_zero();
    salt = $urandom;
    run_dump(0, 0, -1, -1, "zero");
    run_dump(0, 1, -1, -1, "zero_stall");
  endtask

  task automatic test_stall();
    for (int r = 0; r < 4; r++) begin
      salt = $urandom;
      run_dump($urandom_range(1, 5), 1, -1, -1, "stall");
    end
  endtask

  task automatic test_busy_start();
    salt = $urandom;
    spam = 1;
    run_dump(3, 0, -1, 2 + HDR + 3 * BEAT_CYC, "busy_start");
    spam = 0;
    start = 1'b0;
  endtask

  task automatic test_cke();
    salt = $urandom;
    run_dump(2, 0, 1, 2 + HDR + 2 * BEAT_CYC + 10, "cke_freeze");
  endtask

  task automatic test_reset_mid();
    int k, nb;
    salt = $urandom; n_reg = 16'd4; stall_en = 0; lat_max = 0; hold_rd = 0;
    beat_q.delete(); last_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!(hold_rd && rd_pend && rd_addr == A_DAT) && k < 300) begin
      if (beat_q.size() >= 3) hold_rd = 1;
      tick(); k++;
    end
    nvec++;
    if (k >= 300) begin nerr++; $display("FAIL rmid_reach: got timeout expected WAIT_DAT within 300"); end
    nb = beat_q.size();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nvec++;
    if ({busy, done, bus.iob_valid_o, bus.tvalid_o, bus.tlast_o} !== 5'b0 ||
        {bus.iob_addr_o, bus.iob_wstrb_o, bus.iob_wdata_o, bus.tdata_o} !== 76'h0) begin
      nerr++; $display("FAIL rmid_outputs: got ctrl %b tdata %h expected 0", {busy, done, bus.iob_valid_o, bus.tvalid_o, bus.tlast_o}, bus.tdata_o);
    end
    tick();
    hold_rd = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      nvec++;
      if (bus.tvalid_o !== 1'b0 || busy !== 1'b0) begin
        nerr++; $display("FAIL rmid_stray: got tvalid %b busy %b expected 0 0", bus.tvalid_o, busy);
      end
    end
    nvec++;
    if (beat_q.size() != nb) begin nerr++; $display("FAIL rmid_beats: got %0d expected %0d", beat_q.size(), nb); end
    run_dump(2, 0, -1, 2 + HDR + 2 * BEAT_CYC, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_stall();
    test_busy_start();
    test_reset_mid();
    test_cke();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
